projectile_engine: RTL
======================

// Module: projectile_engine
// PURPOSE
//  Parametrised bullet/hit engine for the LED-matrix shooting game. Generalises player count,
//  matrix size, bullets in flight, life depth and fire cooldown. Tracks bullet slots, moves them
//  one row per game tick and resolves hits against shields. Owns life counters and the
//  game-over/winner verdict. Sits between the per-player movement blocks (row/col inputs) and
//  the matrix scan/display block (bullet_map, life, winner outputs).
// PARAMETERS
//  N_PLAYERS  2   players (>=2)
//  ROWS       8   matrix rows; row 0 = top
//  COLS       8   matrix columns
//  SHOTS      4   bullet slots per player; must be even, since each shot is an up/down pair
//  LIFE_INIT  4   life loaded at reset; LW = clog2(LIFE_INIT+1)
//  COOLDOWN   7   ticks a player must wait after firing before the next shot is accepted
// PORTS
//  CLK        in   1              system clock
//  Clear_n    in   1              reset; asynchronous assert, active-low
//  tick       in   1              1-cycle game-step strobe; no state changes on cycles where tick=0
//  fire       in   N_PLAYERS      level fire request, one bit per player
//  shield     in   N_PLAYERS      level defence, one bit per player
//  pos_row    in   N_PLAYERS*RW   player row index, RW=clog2(ROWS); player p at [p*RW +: RW]
//  pos_col    in   N_PLAYERS*CW   player column index, CW=clog2(COLS)
//  life       out  N_PLAYERS*LW   remaining life per player
//  alive      out  N_PLAYERS      1 when life != 0
//  hit_pulse  out  N_PLAYERS      1-cycle pulse: player p lost a life on the last tick
//  bullet_map out  ROWS*COLS      1 = at least one bullet in cell; bit index = row*COLS+col
//  game_over  out  1              1 once at most one player is alive
//  winner     out  N_PLAYERS      one-hot survivor when game_over; all 0 on a draw
// BEHAVIOUR
//  Reset: all slots invalid; cooldowns=0; life=LIFE_INIT; alive all 1; hit_pulse=0;
//   bullet_map=0; game_over=0; winner=0.
//  Reset asserted mid-game clears all state immediately, including bullets in flight.
//  All state commits on a CLK edge with tick=1. Outputs are registered and valid the cycle after.
//  Tick processing order (one combinational pass, single commit):
//   1. Move: each valid slot steps row-1 (UP) or row+1 (DOWN). A slot leaving row 0 upward or
//      row ROWS-1 downward is freed; there is no wrap-around.
//   2. Spawn: player p fires if fire[p], alive[p], !game_over, cooldown[p]==0 and >=2 free slots
//      (counted after step 1). Fire spawns UP at (row-1, col) and DOWN at (row+1, col) in the
//      lowest free slots. A bullet whose spawn row is off-matrix is not created and uses no slot.
//      cooldown[p] loads COOLDOWN on fire; otherwise it decrements to 0 on each tick.
//      A fire request refused for any reason is dropped, not queued.
//   3. Hit: every valid post-move or new bullet sitting on an alive non-owner player's cell is
//      freed. If that player's shield=0, the player takes one damage.
//      Own bullets never hit the owner.
//  Damage: at most 1 life per player per tick, even with multiple hits; life saturates at 0.
//   hit_pulse[p]=1 for exactly the cycle after that tick.
//  Simultaneous fire by several players: each player is evaluated independently. Dead players
//   cannot fire. Their bullets already in flight keep moving and can still hit.
//  game_over is set when popcount(alive)<=1 and is sticky until reset. winner=alive at that time.
//   Mutual last hits on the same tick give a draw (winner=0).
//  After game_over: bullets keep moving and leaving the matrix, but no spawns and no damage.
// STRUCTURE
//  Package shooting_pkg holds:
//   - dir_t enum (UP, DOWN) and bullet_t struct {valid, row, col, dir, owner};
//   - clog2-derived widths RW/CW/LW and a popcount function.
//  Sub-module bullet_slot is one slot register: move/free/load logic, instantiated
//   N_PLAYERS*SHOTS times. The top level does slot allocation, hit resolution, lives and the
//   verdict.
// TESTING
//  1. Reset, then P0 (3,2) fires one tick -> slots (2,2)UP and (4,2)DOWN; bullet_map bits 18
//     and 34 set. After 3 more ticks: UP freed, DOWN at (7,2). One more tick: map empty.
//  2. P0 at (3,2) fires, P1 at (5,2) shield=0 -> on the next tick hit_pulse[1]=1, life[1]=3,
//     DOWN bullet freed. Repeat with shield=1 -> no life change, bullet still freed.
//  3. fire held high for 20 ticks, SHOTS=4 -> spawns on ticks 0, 8 and 16 only (COOLDOWN=7).
//  4. P0 at row 0 fires -> only the DOWN bullet is created; a second fire on the next eligible
//     tick succeeds while that DOWN bullet is still in flight.
//  5. Both players at life 1 hit each other on the same tick -> life=0/0, game_over=1, winner=00.
//     Later fire requests are refused.
//  6. Clear_n pulsed low mid-flight, with no CLK edge -> outputs return to reset values at once.

Source files
------------

// File: rtl/shooting_pkg.sv
// Shared types and helpers for the projectile engine.
// Bullet slots use fixed maximum field widths so one struct serves all sizes.
package shooting_pkg;

    localparam int MAX_RW = 6;
    localparam int MAX_CW = 6;
    localparam int MAX_OW = 4;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    typedef struct packed {
        logic              valid;
        logic [MAX_RW-1:0] row;
        logic [MAX_CW-1:0] col;
        dir_t              dir;
        logic [MAX_OW-1:0] owner;
    } bullet_t;

    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot register: steps its bullet a row per tick,
// frees it at the matrix edge, and accepts a freshly spawned bullet.
module bullet_slot
    import shooting_pkg::*;
#(
    parameter int ROWS = 8
) (
    input  logic    CLK,
    input  logic    Clear_n,
    input  logic    tick,
    input  logic    load_en,
    input  logic    kill,
    input  bullet_t load,
    output bullet_t cur,
    output bullet_t moved
);

    always_comb begin
        moved = cur;
        if (cur.valid) begin
            if (cur.dir == UP) begin
                if (cur.row == '0) moved.valid = 1'b0;
                else moved.row = cur.row - MAX_RW'(1);
            end else begin
                if (cur.row == MAX_RW'(ROWS - 1)) moved.valid = 1'b0;
                else moved.row = cur.row + MAX_RW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge Clear_n) begin
        if (!Clear_n) begin
            cur <= '0;
        end else if (tick) begin
            if (load_en) cur <= load;
            else if (kill) cur <= '0;
            else cur <= moved;
        end
    end

endmodule

// File: rtl/projectile_engine.sv
// Bullet/hit engine: slot allocation, hit resolution, lives and verdict.
// Each player owns a private pool of SHOTS slots.
module projectile_engine
    import shooting_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SHOTS     = 4,
    parameter int LIFE_INIT = 4,
    parameter int COOLDOWN  = 7,
    localparam int RW       = width_of(ROWS),
    localparam int CW       = width_of(COLS),
    localparam int LW       = width_of(LIFE_INIT + 1)
) (
    input  logic                   CLK,
    input  logic                   Clear_n,
    input  logic                   tick,
    input  logic [N_PLAYERS-1:0]   fire,
    input  logic [N_PLAYERS-1:0]   shield,
    input  logic [N_PLAYERS*RW-1:0] pos_row,
    input  logic [N_PLAYERS*CW-1:0] pos_col,
    output logic [N_PLAYERS*LW-1:0] life,
    output logic [N_PLAYERS-1:0]   alive,
    output logic [N_PLAYERS-1:0]   hit_pulse,
    output logic [ROWS*COLS-1:0]   bullet_map,
    output logic                   game_over,
    output logic [N_PLAYERS-1:0]   winner
);

    localparam int NS  = N_PLAYERS * SHOTS;
    localparam int CDW = width_of(COOLDOWN + 1);

    bullet_t cur     [NS];
    bullet_t moved   [NS];
    bullet_t spawn_b [NS];
    logic [NS-1:0] spawn_en;
    logic [NS-1:0] kill;

    logic [RW-1:0] prow [N_PLAYERS];
    logic [CW-1:0] pcol [N_PLAYERS];

    logic [N_PLAYERS-1:0][LW-1:0]  life_q, life_d;
    logic [N_PLAYERS-1:0][CDW-1:0] cd_q, cd_d;
    logic [N_PLAYERS-1:0] alive_q, alive_d;
    logic [N_PLAYERS-1:0] hit_q, dmg, win_q;
    logic go_q;

    for (genvar i = 0; i < NS; i++) begin : g_slot
        bullet_slot #(.ROWS(ROWS)) u_slot (
            .CLK     (CLK),
            .Clear_n (Clear_n),
            .tick    (tick),
            .load_en (spawn_en[i]),
            .kill    (kill[i]),
            .load    (spawn_b[i]),
            .cur     (cur[i]),
            .moved   (moved[i])
        );
    end

    always_comb begin
        for (int p = 0; p < N_PLAYERS; p++) begin
            prow[p] = pos_row[p*RW +: RW];
            pcol[p] = pos_col[p*CW +: CW];
        end
    end

    // Spawn into the lowest free slots of the shooter's pool, then resolve hits
    always_comb begin
        int      nfree;
        logic    want_up;
        logic    want_dn;
        bullet_t b;
        nfree    = 0;
        want_up  = 1'b0;
        want_dn  = 1'b0;
        b        = '0;
        spawn_en = '0;
        kill     = '0;
        dmg      = '0;
        for (int i = 0; i < NS; i++) spawn_b[i] = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            nfree = 0;
            for (int s = 0; s < SHOTS; s++)
                if (!moved[p*SHOTS+s].valid) nfree++;
            cd_d[p] = (cd_q[p] != '0) ? cd_q[p] - CDW'(1) : '0;
            if (fire[p] && alive_q[p] && !go_q && cd_q[p] == '0 && nfree >= 2) begin
                cd_d[p] = CDW'(COOLDOWN);
                want_up = (prow[p] != '0);
                want_dn = (prow[p] != RW'(ROWS - 1));
                for (int s = 0; s < SHOTS; s++) begin
                    if (!moved[p*SHOTS+s].valid && (want_up || want_dn)) begin
                        spawn_en[p*SHOTS+s]      = 1'b1;
                        spawn_b[p*SHOTS+s].valid = 1'b1;
                        spawn_b[p*SHOTS+s].col   = MAX_CW'(pcol[p]);
                        spawn_b[p*SHOTS+s].owner = MAX_OW'(p);
                        if (want_up) begin
                            spawn_b[p*SHOTS+s].dir = UP;
                            spawn_b[p*SHOTS+s].row = MAX_RW'(prow[p]) - MAX_RW'(1);
                            want_up = 1'b0;
                        end else begin
                            spawn_b[p*SHOTS+s].dir = DOWN;
                            spawn_b[p*SHOTS+s].row = MAX_RW'(prow[p]) + MAX_RW'(1);
                            want_dn = 1'b0;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            b = spawn_en[i] ? spawn_b[i] : moved[i];
            for (int q = 0; q < N_PLAYERS; q++) begin
                if (b.valid && alive_q[q] && b.owner != MAX_OW'(q) &&
                    b.row == MAX_RW'(prow[q]) && b.col == MAX_CW'(pcol[q])) begin
                    if (spawn_en[i]) spawn_b[i].valid = 1'b0;
                    else kill[i] = 1'b1;
                    if (!shield[q] && !go_q) dmg[q] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PLAYERS; p++) begin
            life_d[p]  = (dmg[p] && life_q[p] != '0) ? life_q[p] - LW'(1) : life_q[p];
            alive_d[p] = (life_d[p] != '0);
        end
    end

    always_comb begin
        bullet_map = '0;
        for (int i = 0; i < NS; i++)
            if (cur[i].valid)
                bullet_map[int'(cur[i].row)*COLS + int'(cur[i].col)] = 1'b1;
    end

    always_ff @(posedge CLK or negedge Clear_n) begin
        if (!Clear_n) begin
            for (int p = 0; p < N_PLAYERS; p++) life_q[p] <= LW'(LIFE_INIT);
            cd_q    <= '0;
            alive_q <= '1;
            hit_q   <= '0;
            win_q   <= '0;
            go_q    <= 1'b0;
        end else begin
            hit_q <= '0;
            if (tick) begin
                life_q  <= life_d;
                alive_q <= alive_d;
                cd_q    <= cd_d;
                hit_q   <= dmg;
                if (!go_q && popcount(32'(alive_d)) <= 1) begin
                    go_q  <= 1'b1;
                    win_q <= alive_d;
                end
            end
        end
    end

    assign life      = life_q;
    assign alive     = alive_q;
    assign hit_pulse = hit_q;
    assign game_over = go_q;
    assign winner    = win_q;

endmodule
